// File: rtl/branch_resolve.sv
// branch_resolve: resolves decode-stage branches/jumps into a registered PC redirect,
// a multi-cycle flush of younger instructions, and saturating branch statistics.
module branch_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InstValid,
    input  logic             Branch,
    input  logic             Jump,
    input  logic [2:0]       Funct3,
    input  logic [31:0]      Target,
    input  logic             BrLT,
    input  logic             BrEq,
    output logic             BrUn,
    output logic             PCSel,
    output logic [31:0]      RedirPC,
    output logic             Flush,
    output logic             IllegalBr,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] TakenCnt
);
    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;
    // FLUSH-state cycles still to go after the current one
    localparam logic [3:0] FC_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
    state_t           r_state, w_next;
    logic [3:0]       r_fcnt;
    logic             r_pcsel, r_flush, r_illegal;
    logic [31:0]      r_redir;
    logic [CNT_W-1:0] r_bcnt, r_tcnt;
    logic             w_accept, w_legal, w_cond, w_cbr, w_take, w_pcsel_d, w_flush_d;
    assign BrUn      = Funct3[1];
    assign PCSel     = r_pcsel;
    assign Flush     = r_flush;
    assign IllegalBr = r_illegal;
    assign RedirPC   = r_redir;
    assign BranchCnt = r_bcnt;
    assign TakenCnt  = r_tcnt;
    assign w_accept = InstValid && (r_state == IDLE);
    assign w_legal  = Funct3[2:1] != 2'b01;
    // funct3[0] inverts the sense: BNE/BGE/BGEU are complements of BEQ/BLT/BLTU
    assign w_cond   = Funct3[2] ? (BrLT ^ Funct3[0]) : (BrEq ^ Funct3[0]);
    assign w_cbr    = w_accept && Branch && !Jump && w_legal;
    assign w_take   = w_accept && (Jump || (Branch && w_legal && w_cond));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_fcnt  <= 4'd0;
        end else begin
            r_state <= w_next;
            r_fcnt  <= (r_state == REDIRECT) ? FC_INIT :
                       (r_state == FLUSH && r_fcnt != 4'd0) ? r_fcnt - 4'd1 : r_fcnt;
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_take ? REDIRECT : IDLE;
            REDIRECT: w_next = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
            FLUSH:    w_next = (r_fcnt == 4'd0) ? IDLE : FLUSH;
            default:  w_next = IDLE;
        endcase
    end
    always_comb begin
        w_pcsel_d = w_next == REDIRECT;
        w_flush_d = w_next != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcsel   <= 1'b0;
            r_flush   <= 1'b0;
            r_illegal <= 1'b0;
            r_redir   <= 32'd0;
            r_bcnt    <= '0;
            r_tcnt    <= '0;
        end else begin
            r_pcsel   <= w_pcsel_d;
            r_flush   <= w_flush_d;
            r_illegal <= w_accept && Branch && !Jump && !w_legal;
            r_redir   <= w_take ? (Target & 32'hFFFF_FFFE) : r_redir;
            r_bcnt    <= (w_cbr && r_bcnt != '1) ? r_bcnt + CNT_W'(1) : r_bcnt;
            r_tcnt    <= (w_cbr && w_cond && r_tcnt != '1) ? r_tcnt + CNT_W'(1) : r_tcnt;
        end
    end
endmodule
